// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register.
// Captures decoded instruction fields from ID and presents them to EXE one
// clock later. Supports hazard freeze, branch flush (bubble insertion) and
// keeps saturating statistics of stall and flush cycles.
module id_exe_reg #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             valid_in,
  input  logic             WB_EN_in,
  input  logic             MEM_R_EN_in,
  input  logic             MEM_W_EN_in,
  input  logic             B_in,
  input  logic             S_in,
  input  logic             imm_in,
  input  logic [3:0]       EXE_CMD_in,
  input  logic [PC_W-1:0]  PC_in,
  input  logic [PC_W-1:0]  Val_Rn_in,
  input  logic [PC_W-1:0]  Val_Rm_in,
  input  logic [11:0]      Shift_operand_in,
  input  logic [23:0]      Signed_imm_24_in,
  input  logic [3:0]       Dest_in,
  input  logic [3:0]       src1_in,
  input  logic [3:0]       src2_in,
  input  logic [3:0]       SR_in,
  output logic             valid_out,
  output logic             WB_EN_out,
  output logic             MEM_R_EN_out,
  output logic             MEM_W_EN_out,
  output logic             B_out,
  output logic             S_out,
  output logic             imm_out,
  output logic [3:0]       EXE_CMD_out,
  output logic [PC_W-1:0]  PC_out,
  output logic [PC_W-1:0]  Val_Rn_out,
  output logic [PC_W-1:0]  Val_Rm_out,
  output logic [11:0]      Shift_operand_out,
  output logic [23:0]      Signed_imm_24_out,
  output logic [3:0]       Dest_out,
  output logic [3:0]       src1_out,
  output logic [3:0]       src2_out,
  output logic [3:0]       SR_out,
  output logic             MEM_out,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Control bits only survive capture for a real instruction; a bubble still
  // carries its data fields so downstream forwarding logic sees stable values.
  logic keep_ctrl;
  assign keep_ctrl = valid_in;

  // Pipeline field register: flush beats freeze beats normal capture.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of all others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out         <= 1'b0;
      WB_EN_out         <= 1'b0;
      MEM_R_EN_out      <= 1'b0;
      MEM_W_EN_out      <= 1'b0;
      B_out             <= 1'b0;
      S_out             <= 1'b0;
      imm_out           <= 1'b0;
      EXE_CMD_out       <= '0;
      PC_out            <= '0;
      Val_Rn_out        <= '0;
      Val_Rm_out        <= '0;
      Shift_operand_out <= '0;
      Signed_imm_24_out <= '0;
      Dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      SR_out            <= '0;
    end else if (flush) begin
      valid_out         <= 1'b0;
      WB_EN_out         <= 1'b0;
      MEM_R_EN_out      <= 1'b0;
      MEM_W_EN_out      <= 1'b0;
      B_out             <= 1'b0;
      S_out             <= 1'b0;
      imm_out           <= 1'b0;
      EXE_CMD_out       <= '0;
      PC_out            <= '0;
      Val_Rn_out        <= '0;
      Val_Rm_out        <= '0;
      Shift_operand_out <= '0;
      Signed_imm_24_out <= '0;
      Dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      SR_out            <= '0;
    end else if (!freeze) begin
      valid_out         <= valid_in;
      WB_EN_out         <= WB_EN_in & keep_ctrl;
      // A write wins over a read so the two enables are never both set.
      MEM_R_EN_out      <= MEM_R_EN_in & ~MEM_W_EN_in & keep_ctrl;
      MEM_W_EN_out      <= MEM_W_EN_in & keep_ctrl;
      B_out             <= B_in & keep_ctrl;
      S_out             <= S_in & keep_ctrl;
      imm_out           <= imm_in;
      EXE_CMD_out       <= EXE_CMD_in;
      PC_out            <= PC_in;
      Val_Rn_out        <= Val_Rn_in;
      Val_Rm_out        <= Val_Rm_in;
      Shift_operand_out <= Shift_operand_in;
      Signed_imm_24_out <= Signed_imm_24_in;
      Dest_out          <= Dest_in;
      src1_out          <= src1_in;
      src2_out          <= src2_in;
      SR_out            <= SR_in;
    end
  end

  // Stall statistics: count frozen edges that were not overridden by a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (freeze && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Flush statistics: count every flushing edge, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt <= '0;
    end else if (flush && (flush_cnt != '1)) begin
      flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Memory-access flag derived purely from registered enables.
  assign MEM_out = MEM_R_EN_out | MEM_W_EN_out;

endmodule

// File: tb/tb_id_exe_reg.sv
// Scoreboard bench for id_exe_reg: a driver applies stimulus on the falling
// edge and queues the expected post-edge state from a field-level model; a
// monitor compares the DUT against the queue just after each rising edge.
module tb_id_exe_reg;

  localparam int PC_W    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic        valid, wb, mr, mw, b, s, imm;
    logic [3:0]  cmd;
    logic [31:0] pc, rn, rm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dest, s1, s2, sr;
  } fields_t;

  typedef struct {
    fields_t f;
    logic    mem;
    int      stall;
    int      flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst, rst_nxt;
  logic freeze, flush, valid_in;
  logic WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, imm_in;
  logic [3:0] EXE_CMD_in, Dest_in, src1_in, src2_in, SR_in;
  logic [PC_W-1:0] PC_in, Val_Rn_in, Val_Rm_in;
  logic [11:0] Shift_operand_in;
  logic [23:0] Signed_imm_24_in;
  logic valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, imm_out;
  logic [3:0] EXE_CMD_out, Dest_out, src1_out, src2_out, SR_out;
  logic [PC_W-1:0] PC_out, Val_Rn_out, Val_Rm_out;
  logic [11:0] Shift_operand_out;
  logic [23:0] Signed_imm_24_out;
  logic MEM_out;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];

  // Reference state: what the stage register should hold, plus event counts.
  fields_t model_st;
  int      model_stalls;
  int      model_flushes;

  id_exe_reg #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .B_in(B_in), .S_in(S_in), .imm_in(imm_in), .EXE_CMD_in(EXE_CMD_in),
    .PC_in(PC_in), .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in),
    .Shift_operand_in(Shift_operand_in), .Signed_imm_24_in(Signed_imm_24_in),
    .Dest_in(Dest_in), .src1_in(src1_in), .src2_in(src2_in), .SR_in(SR_in),
    .valid_out(valid_out), .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out),
    .MEM_W_EN_out(MEM_W_EN_out), .B_out(B_out), .S_out(S_out), .imm_out(imm_out),
    .EXE_CMD_out(EXE_CMD_out), .PC_out(PC_out), .Val_Rn_out(Val_Rn_out),
    .Val_Rm_out(Val_Rm_out), .Shift_operand_out(Shift_operand_out),
    .Signed_imm_24_out(Signed_imm_24_out), .Dest_out(Dest_out),
    .src1_out(src1_out), .src2_out(src2_out), .SR_out(SR_out),
    .MEM_out(MEM_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare(input exp_t e);
    check("valid_out", 64'(valid_out), 64'(e.f.valid));
    check("WB_EN_out", 64'(WB_EN_out), 64'(e.f.wb));
    check("MEM_R_EN_out", 64'(MEM_R_EN_out), 64'(e.f.mr));
    check("MEM_W_EN_out", 64'(MEM_W_EN_out), 64'(e.f.mw));
    check("B_out", 64'(B_out), 64'(e.f.b));
    check("S_out", 64'(S_out), 64'(e.f.s));
    check("imm_out", 64'(imm_out), 64'(e.f.imm));
    check("EXE_CMD_out", 64'(EXE_CMD_out), 64'(e.f.cmd));
    check("PC_out", 64'(PC_out), 64'(e.f.pc));
    check("Val_Rn_out", 64'(Val_Rn_out), 64'(e.f.rn));
    check("Val_Rm_out", 64'(Val_Rm_out), 64'(e.f.rm));
    check("Shift_operand_out", 64'(Shift_operand_out), 64'(e.f.sh));
    check("Signed_imm_24_out", 64'(Signed_imm_24_out), 64'(e.f.si));
    check("Dest_out", 64'(Dest_out), 64'(e.f.dest));
    check("src1_out", 64'(src1_out), 64'(e.f.s1));
    check("src2_out", 64'(src2_out), 64'(e.f.s2));
    check("SR_out", 64'(SR_out), 64'(e.f.sr));
    check("MEM_out", 64'(MEM_out), 64'(e.mem));
    check("stall_cnt", 64'(stall_cnt), 64'(e.stall));
    check("flush_cnt", 64'(flush_cnt), 64'(e.flush));
  endtask

  function automatic fields_t zero_fields();
    fields_t z;
    z = '{valid: 1'b0, wb: 1'b0, mr: 1'b0, mw: 1'b0, b: 1'b0, s: 1'b0, imm: 1'b0,
          cmd: 4'h0, pc: 32'h0, rn: 32'h0, rm: 32'h0, sh: 12'h0, si: 24'h0,
          dest: 4'h0, s1: 4'h0, s2: 4'h0, sr: 4'h0};
    return z;
  endfunction

  function automatic fields_t rand_fields();
    fields_t r;
    r.valid = ($urandom_range(0, 9) < 7);
    r.wb    = 1'($urandom);
    r.mr    = 1'($urandom);
    r.mw    = 1'($urandom);
    r.b     = 1'($urandom);
    r.s     = 1'($urandom);
    r.imm   = 1'($urandom);
    r.cmd   = 4'($urandom);
    r.pc    = $urandom;
    r.rn    = $urandom;
    r.rm    = $urandom;
    r.sh    = 12'($urandom);
    r.si    = 24'($urandom);
    r.dest  = 4'($urandom);
    r.s1    = 4'($urandom);
    r.s2    = 4'($urandom);
    r.sr    = 4'($urandom);
    return r;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.f     = model_st;
    e.mem   = model_st.mr | model_st.mw;
    e.stall = (model_stalls > CNT_MAX) ? CNT_MAX : model_stalls;
    e.flush = (model_flushes > CNT_MAX) ? CNT_MAX : model_flushes;
    return e;
  endfunction

  task automatic model_reset();
    model_st      = zero_fields();
    model_stalls  = 0;
    model_flushes = 0;
  endtask

  // Apply one cycle of stimulus on the falling edge and queue the expectation.
  task automatic drive(input fields_t f, input bit fr, input bit fl);
    @(negedge clk);
    rst              = rst_nxt;
    freeze           = fr;
    flush            = fl;
    valid_in         = f.valid;
    WB_EN_in         = f.wb;
    MEM_R_EN_in      = f.mr;
    MEM_W_EN_in      = f.mw;
    B_in             = f.b;
    S_in             = f.s;
    imm_in           = f.imm;
    EXE_CMD_in       = f.cmd;
    PC_in            = f.pc;
    Val_Rn_in        = f.rn;
    Val_Rm_in        = f.rm;
    Shift_operand_in = f.sh;
    Signed_imm_24_in = f.si;
    Dest_in          = f.dest;
    src1_in          = f.s1;
    src2_in          = f.s2;
    SR_in            = f.sr;
    if (rst) begin
      if (fl) begin
        model_st = zero_fields();
        model_flushes++;
      end else if (fr) begin
        model_stalls++;
      end else begin
        model_st = f;
        if (!f.valid) begin
          model_st.wb = 1'b0;
          model_st.mr = 1'b0;
          model_st.mw = 1'b0;
          model_st.b  = 1'b0;
          model_st.s  = 1'b0;
        end
        if (model_st.mr && model_st.mw) model_st.mr = 1'b0;
      end
    end
    exp_q.push_back(snapshot());
  endtask

  // Monitor: one expectation per rising edge, compared just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) compare(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fields_t f;
    rst = 1'b0;
    rst_nxt = 1'b0;
    freeze = 1'b0;
    flush = 1'b0;
    model_reset();
    f = rand_fields();
    valid_in = 1'b1; WB_EN_in = 1'b1; MEM_R_EN_in = 1'b1; MEM_W_EN_in = 1'b0;
    B_in = 1'b1; S_in = 1'b1; imm_in = 1'b1; EXE_CMD_in = 4'hF;
    PC_in = 32'hFFFF_FFFF; Val_Rn_in = 32'h1; Val_Rm_in = 32'h2;
    Shift_operand_in = 12'hFFF; Signed_imm_24_in = 24'hFFFFFF;
    Dest_in = 4'hF; src1_in = 4'hF; src2_in = 4'hF; SR_in = 4'hF;
    #2;
    compare(snapshot());

    // Edges while reset is held must not capture anything.
    repeat (3) drive(rand_fields(), 1'b0, 1'b0);
    rst_nxt = 1'b1;

    // Plain capture with a memory read.
    f = zero_fields();
    f.valid = 1'b1; f.rm = 32'hDEAD_BEEF; f.sh = 12'h3A5; f.mr = 1'b1;
    drive(f, 1'b0, 1'b0);

    // Freeze holds a loaded PC for three edges, then release.
    f = zero_fields();
    f.valid = 1'b1; f.pc = 32'h10;
    drive(f, 1'b0, 1'b0);
    f.pc = 32'h14;
    repeat (3) drive(f, 1'b1, 1'b0);
    drive(f, 1'b0, 1'b0);

    // Flush wins over freeze.
    f = rand_fields();
    f.valid = 1'b1; f.wb = 1'b1;
    drive(f, 1'b1, 1'b1);

    // Bubble keeps data but drops control.
    f = zero_fields();
    f.valid = 1'b0; f.mw = 1'b1; f.rn = 32'h55;
    drive(f, 1'b0, 1'b0);

    // Read and write requested together: write wins.
    f = rand_fields();
    f.valid = 1'b1; f.mr = 1'b1; f.mw = 1'b1;
    drive(f, 1'b0, 1'b0);

    // Randomized mix of capture, bubble, freeze and flush.
    for (int i = 0; i < 200; i++) begin
      drive(rand_fields(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0));
    end

    // Counter saturation at all-ones.
    repeat (20) drive(rand_fields(), 1'b1, 1'b0);
    repeat (20) drive(rand_fields(), 1'b0, 1'b1);

    // Load real state, then reset asynchronously in the middle of a stall.
    f = rand_fields();
    f.valid = 1'b1; f.pc = 32'hA5A5_0001;
    drive(f, 1'b0, 1'b0);
    drive(rand_fields(), 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    rst_nxt = 1'b0;
    model_reset();
    #1;
    compare(snapshot());
    repeat (2) drive(rand_fields(), 1'b0, 1'b0);

    // Freeze right after release holds the zero state.
    rst_nxt = 1'b1;
    repeat (2) drive(rand_fields(), 1'b1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      drive(rand_fields(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0));
    end

    // Let the monitor drain the scoreboard within a bounded number of edges.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
